// File: rtl/max10nios_pio_in_irq.sv
// Avalon-MM input PIO slave: synchronised WIDTH-bit input, per-bit edge capture,
// interrupt mask and a single IRQ. Read data is registered (1-cycle latency).
module max10nios_pio_in_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_d1_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits are architecturally ignored.
  assign unused_wdata = ^writedata;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign data_in = in_port;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign data_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_det = data_in ^ data_d1_q;
    if (EDGE_TYPE == 0) edge_det = data_in & ~data_d1_q;
    else if (EDGE_TYPE == 1) edge_det = ~data_in & data_d1_q;
  end

  // Detected edges are OR'd in after the clear so a same-cycle edge wins.
  always_comb begin
    clr_bits = '0;
    if (wr_en && address == 2'd3) begin
      clr_bits = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    end
    edge_capture_d = (edge_capture_q & ~clr_bits) | edge_det;
  end

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_in;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d1_q      <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      data_d1_q      <= data_in;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq = (IRQ_TYPE != 0) ? |(edge_capture_q & irq_mask_q)
                               : |(data_in & irq_mask_q);

endmodule

// File: tb/tb_max10nios_pio_in_irq.sv
// Scoreboard bench for max10nios_pio_in_irq: two configurations share one stimulus
// stream; a pin-history reference model predicts readdata/irq for every clock edge.
module tb_max10nios_pio_in_irq;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_a, rd_b;
  logic          irq_a, irq_b;

  always #5 clk = ~clk;

  // A: default build. B: no synchroniser, any-edge, level irq, clear-all.
  max10nios_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1), .BIT_CLEAR(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  max10nios_pio_in_irq #(.WIDTH(W), .SYNC_STAGES(0), .EDGE_TYPE(2), .IRQ_TYPE(0), .BIT_CLEAR(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_b), .irq(irq_b)
  );

  int cfg_sync [2] = '{2, 0};
  int cfg_edge [2] = '{0, 2};
  int cfg_irq  [2] = '{1, 0};
  int cfg_bclr [2] = '{1, 0};

  // hist[j] = pin value sampled j edges before the edge being modelled.
  logic [W-1:0] hist [8];
  logic [W-1:0] m_mask [2];
  logic [W-1:0] m_cap  [2];
  logic [32:0]  exp_q_a [$];
  logic [32:0]  exp_q_b [$];
  logic [W-1:0] cur_pin;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 8; j++) hist[j] = '0;
    for (int c = 0; c < 2; c++) begin
      m_mask[c] = '0;
      m_cap[c]  = '0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  // Predict the outputs just after the coming clock edge.
  task automatic model_step(input logic [1:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [W-1:0] pin);
    logic [W-1:0] di, dd, da, ev, clr;
    logic [31:0]  rd;
    logic         wr, irq_e;
    int           s;
    for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = pin;
    wr = cs && !wn;
    for (int c = 0; c < 2; c++) begin
      s  = cfg_sync[c];
      di = hist[s];
      dd = hist[s+1];
      da = hist[(s > 0) ? s - 1 : 0];
      case (cfg_edge[c])
        0:       ev = di & ~dd;
        1:       ev = ~di & dd;
        default: ev = di ^ dd;
      endcase
      case (a)
        2'd0:    rd = 32'(di);
        2'd2:    rd = 32'(m_mask[c]);
        2'd3:    rd = 32'(m_cap[c]);
        default: rd = 32'd0;
      endcase
      clr = '0;
      if (wr && a == 2'd3) clr = (cfg_bclr[c] != 0) ? wd[W-1:0] : '1;
      m_cap[c] = (m_cap[c] & ~clr) | ev;
      if (wr && a == 2'd2) m_mask[c] = wd[W-1:0];
      irq_e = (cfg_irq[c] != 0) ? |(m_cap[c] & m_mask[c]) : |(da & m_mask[c]);
      if (c == 0) exp_q_a.push_back({irq_e, rd});
      else        exp_q_b.push_back({irq_e, rd});
    end
  endtask

  task automatic apply_now(input logic [1:0] a, input logic cs, input logic wn,
                           input logic [31:0] wd);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = cur_pin;
    model_step(a, cs, wn, wd, cur_pin);
  endtask

  task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    @(negedge clk);
    apply_now(a, cs, wn, wd);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    drive(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    drive(a, 1'b1, 1'b1, 32'hDEAD_BEEF);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_port = cur_pin;
    model_reset();
    #1;
    check("rst_readdata_a", rd_a, 32'h0);
    check("rst_irq_a", 32'(irq_a), 32'h0);
    check("rst_readdata_b", rd_b, 32'h0);
    check("rst_irq_b", 32'(irq_b), 32'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_readdata_a", rd_a, 32'h0);
    check("rst_hold_readdata_b", rd_b, 32'h0);
    reset_n = 1'b1;
    apply_now(2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  // Monitor: every edge produces a registered read result; compare it.
  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      check("a_readdata", rd_a, e[31:0]);
      check("a_irq", 32'(irq_a), 32'(e[32]));
    end
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      check("b_readdata", rd_b, e[31:0]);
      check("b_irq", 32'(irq_b), 32'(e[32]));
    end
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    cur_pin    = '0;
    in_port    = '0;
    apply_reset();

    for (int a = 0; a < 4; a++) rd_reg(2'(a));

    cur_pin = 8'hA5;
    idle(5);
    cur_pin = 8'h00;
    idle(5);
    wr_reg(2'd3, 32'hFF);
    idle(1);

    wr_reg(2'd2, 32'h01);
    cur_pin = 8'h01;
    idle(4);
    rd_reg(2'd3);
    wr_reg(2'd3, 32'h01);
    rd_reg(2'd3);

    wr_reg(2'd2, 32'h00);
    cur_pin = 8'h09;
    idle(2);
    cur_pin = 8'h01;
    idle(4);
    rd_reg(2'd3);
    wr_reg(2'd2, 32'h08);
    idle(2);

    // Rising edge on bit 1 lands on the same edge as its clear.
    wr_reg(2'd3, 32'hFF);
    idle(3);
    cur_pin = 8'h03;
    idle(2);
    wr_reg(2'd3, 32'h02);
    rd_reg(2'd3);
    rd_reg(2'd3);

    wr_reg(2'd2, 32'h10);
    cur_pin = cur_pin | 8'h10;
    idle(3);
    cur_pin = cur_pin & ~8'h10;
    idle(3);

    wr_reg(2'd3, 32'h0);
    rd_reg(2'd3);

    cur_pin = 8'hFF;
    idle(1);
    apply_reset();
    idle(5);
    rd_reg(2'd3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur_pin = cur_pin ^ W'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 49) == 0) cur_pin = W'($urandom);
      if ($urandom_range(0, 199) == 0) apply_reset();
      else drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), $urandom);
    end

    idle(2);
    @(negedge clk);
    check("a_queue_drained", exp_q_a.size(), 32'd0);
    check("b_queue_drained", exp_q_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max10nios_pio_in_irq.md
Name: max10nios_pio_in_irq

Overview:
Parametrised Avalon-MM input PIO slave for the Nios II subsystem. It is the successor to the fixed 1-bit status-input port.
- Samples a WIDTH-bit input bus through a synchroniser.
- Provides per-bit edge capture, an interrupt mask and a single interrupt request to the CPU.
- Read data is registered, matching the existing input-port timing, so software drivers for the data register are unchanged.

Parameters:
WIDTH, 8, input bus width; legal range 1..32.
SYNC_STAGES, 2, synchroniser flops on in_port; 0 means in_port is used directly.
EDGE_TYPE, 0, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
IRQ_TYPE, 1, interrupt source: 0 = level (data & mask), 1 = edge (capture & mask).
BIT_CLEAR, 1, edge-capture clear mode: 1 = write-1-to-clear per bit; 0 = any write clears all bits.

Ports:
clk  input  1  system clock; sole clock domain.
reset_n  input  1  asynchronous active-low reset.
address  input  2  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe.
writedata  input  32  write data; bits above WIDTH ignored.
in_port  input  WIDTH  external inputs, asynchronous to clk.
readdata  output  32  registered read data; zero-extended.
irq  output  1  interrupt request, active high.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset state: readdata=0, irq=0. Synchroniser flops, data_in, data_d1, irq_mask and edge_capture all reset to 0.
- Synchroniser: data_in = in_port delayed by SYNC_STAGES clk edges, as a flop chain.
- Register map:
  - 0 = data (read-only; writes ignored).
  - 1 = reserved; reads 0, writes ignored.
  - 2 = irq_mask (R/W).
  - 3 = edge_capture (R, clear-on-write).
- Write: occurs when chipselect=1 and write_n=0 on a clk edge.
- Read: readdata updates on every clk edge from the address mux, independent of chipselect. Read latency is 1 cycle after address is presented.
- Edge detect: data_d1 <= data_in every cycle.
  - Rising edge = data_in & ~data_d1.
  - Falling edge = ~data_in & data_d1.
  - Any edge = XOR of the two values.
- edge_capture[i] is set on the clk edge after the edge is detected and holds until cleared.
- Clear:
  - BIT_CLEAR=1: a write to address 3 clears bits where writedata[i]=1.
  - BIT_CLEAR=0: any write to address 3 clears all bits.
- Simultaneous detected edge and clear on the same bit: set wins; the bit remains 1.
- irq is combinational from registers only:
  - IRQ_TYPE=1: irq = |(edge_capture & irq_mask).
  - IRQ_TYPE=0: irq = |(data_in & irq_mask).
- Latency, pin to data register: change visible in readdata at SYNC_STAGES+1 edges with address=0 held.
- Latency, pin to irq (edge mode, mask set): irq asserts SYNC_STAGES+1 edges after the pin change.
- Reset release with an input already high: data_d1 starts at 0, so a rising edge is captured SYNC_STAGES+1 cycles after release. This is intended; software clears edge_capture at init.
- Reset asserted mid-operation: all state clears immediately; any pending capture is lost.
- Unused readdata bits [31:WIDTH] are always 0.

Test Plan:
1. Reset values: assert reset_n=0, then release; read addresses 0..3 -> readdata=0 for all four, irq=0.
2. Data path: WIDTH=8, SYNC_STAGES=2; set in_port=8'hA5, hold address=0 -> readdata=32'h000000A5 exactly 3 edges after in_port changes.
3. Rising capture and irq: write irq_mask=8'h01, then toggle in_port[0] 0->1.
   - Expect edge_capture=8'h01 and irq=1 at SYNC_STAGES+1 edges.
   - Then write 8'h01 to address 3 -> irq=0 next cycle; readdata at addr 3 = 0.
4. Masking: pulse in_port[3] with irq_mask=0 -> edge_capture=8'h08, irq stays 0. Then write irq_mask=8'h08 -> irq=1 the next cycle.
5. Clear collision: time a write of 8'h02 to address 3 on the same edge a new in_port[1] rising edge is detected -> edge_capture[1] stays 1.
6. Modes:
   - EDGE_TYPE=2: pulse 0->1->0 -> two captures; bit remains set.
   - IRQ_TYPE=0, mask=8'h10, in_port[4]=1 -> irq=1; drop the pin -> irq=0.
   - BIT_CLEAR=0: write 0 to address 3 clears all bits.
